// File: rtl/count_reg_ctrl.sv
// Loadable down-counter with terminal-count pulse, optional auto-reload and preset.
// count_q, tc and busy are all registered; ld_ready is the only combinational output.
//
//   state | meaning
//   IDLE  | waiting for a load; en ignored, count_q held
//   RUN   | counting down on en; expiry at count_q == 1
module count_reg_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             preset,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_d;
  logic             ld_accept;

  assign ld_ready  = (state_q == IDLE) & ~preset;
  assign ld_accept = ld_valid & ld_ready;
  assign busy      = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (preset) begin
      // preset leaves reload_q alone so a later auto-reload still uses the last load
      count_d = '1;
      state_d = RUN;
    end else if (state_q == IDLE) begin
      if (ld_accept) begin
        count_d  = ld_data;
        reload_d = ld_data;
        if (ld_data == '0) tc_d = 1'b1;
        else               state_d = RUN;
      end
    end else if (en) begin
      if (count_q == ONE) begin
        tc_d = 1'b1;
        if (auto_reload && (reload_q != '0)) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end else if (count_q > ONE) begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc       <= tc_d;
    end
  end

endmodule

// File: doc/count_reg_ctrl.md
COUNT_REG_CTRL -- requirements
Module: count_reg_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port preset, input, 1: force counter to all-ones and enter RUN.
REQ-005 SHALL have port ld_valid, input, 1: load request qualifier.
REQ-006 SHALL have port ld_data, input, WIDTH: load value, sampled on load accept.
REQ-007 SHALL have port ld_ready, output, 1: block can accept a load this cycle.
REQ-008 SHALL have port en, input, 1: count enable; decrement permitted when high.
REQ-009 SHALL have port auto_reload, input, 1: on expiry, restart from the last loaded value.
REQ-010 SHALL have port count_q, output, WIDTH: registered counter value.
REQ-011 SHALL have port tc, output, 1: registered terminal-count pulse.
REQ-012 SHALL have port busy, output, 1: high while in RUN.

Function
REQ-013 SHALL implement two states, IDLE and RUN, with busy = (state == RUN).
REQ-014 SHALL drive ld_ready = (state == IDLE) & ~preset, combinationally.
REQ-015 SHALL accept a load when ld_valid & ld_ready at a rising edge, writing ld_data to count_q and to internal reload_reg.
REQ-016 On an accepted load with ld_data != 0, SHALL enter RUN.
REQ-017 On an accepted load with ld_data == 0, SHALL stay in IDLE and assert tc in the following cycle.
REQ-018 In RUN with en = 1 and count_q > 1, SHALL set count_q <= count_q - 1 (modulo 2^WIDTH).
REQ-019 In RUN with en = 0, SHALL hold count_q and the state.
REQ-020 Expiry is defined as RUN & en & count_q == 1.
REQ-021 On expiry, SHALL set tc high for exactly the next cycle.
REQ-022 On expiry with auto_reload = 1 and reload_reg != 0, SHALL load count_q <= reload_reg and stay in RUN.
REQ-023 On expiry otherwise, SHALL set count_q <= 0 and go to IDLE.
REQ-024 In IDLE, en SHALL have no effect; count_q holds and never wraps below 0.
REQ-025 preset SHALL have highest priority over load, count and expiry: count_q <= all-ones, state <= RUN, tc <= 0; reload_reg is unchanged.
REQ-026 In RUN, ld_valid SHALL be ignored; no load is accepted and reload_reg does not change.
REQ-027 tc SHALL be low in every cycle not covered by REQ-017 or REQ-021; a continuous auto-reload of 1 gives tc high every cycle.
REQ-028 Latency: each change to count_q SHALL be visible one edge after the qualifying inputs; there is no combinational path from inputs to count_q, tc or busy.

Reset
REQ-029 While rst_n = 0, SHALL asynchronously force count_q = 0, reload_reg = 0, state = IDLE and tc = 0, giving busy = 0 and ld_ready = ~preset.
REQ-030 Reset asserted mid-count SHALL abort the count immediately with no tc pulse.
REQ-031 After rst_n deasserts, the first state update SHALL occur at the next rising clk edge.

Verification
REQ-032 SHALL cover: WIDTH=16, load 3 with en held high -> count_q 3, 2, 1, 0; tc high one cycle with count_q = 0; busy falls together with tc rising.
REQ-033 SHALL cover: load 2, auto_reload = 1, en = 1 -> count_q 2, 1, 2, 1, ...; tc pulses every second cycle; busy stays 1.
REQ-034 SHALL cover: preset and ld_valid both high in IDLE -> ld_ready = 0, count_q = 0xFFFF, busy = 1, reload_reg unchanged.
REQ-035 SHALL cover: load 0 -> count_q = 0, tc = 1 next cycle, state stays IDLE; a load of 5 on the following cycle is accepted.
REQ-036 SHALL cover: load 0x0010, en toggled every cycle -> count_q decrements only on en = 1 edges; ld_valid pulses while busy are ignored.
REQ-037 SHALL cover: rst_n pulled low asynchronously at count_q = 0x0007 between edges -> count_q = 0 and busy = 0 at once, with no tc pulse.
